// File: rtl/complex_pkg.sv
// complex_pkg: shared encodings, FSM states and types for the complex execution unit.
package complex_pkg;

    // Decoded alu_op encodings for complex ops (complex=1).
    localparam logic [4:0] OP_ADD   = 5'b10011;
    localparam logic [4:0] OP_SUB   = 5'b10100;
    localparam logic [4:0] OP_MUL   = 5'b10101;
    localparam logic [4:0] OP_DIV   = 5'b10110;
    localparam logic [4:0] OP_RSV17 = 5'b10111;
    localparam logic [4:0] OP_CONJ  = 5'b11000;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_RSV1A = 5'b11010;
    localparam logic [4:0] OP_RSV1B = 5'b11011;
    localparam logic [4:0] OP_RSV1C = 5'b11100;
    localparam logic [4:0] OP_RSV1D = 5'b11101;
    localparam logic [4:0] OP_RSV1E = 5'b11110;

    // Cycles spent on the shared multiplier by MUL and by the DIV pre-products.
    localparam int unsigned MUL_CYCLES  = 4;
    localparam int unsigned DMUL_CYCLES = 6;

    localparam int unsigned CPLX_DW = 16;

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDmul,
        StDprep,
        StDiter,
        StDone
    } cstate_e;

    // Build a packed complex word from its two halves.
    function automatic cplx_t cplx_pack(input logic signed [CPLX_DW-1:0] re,
                                        input logic signed [CPLX_DW-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/complex_divider.sv
// complex_divider: two-lane restoring divider (|num| / den per lane, sign reapplied,
// truncation toward zero). Only built when COMPLEX_DIV_EN is defined.
// done is combinational in the last iteration cycle and quo_* carry the final quotient then.
`ifdef COMPLEX_DIV_EN
module complex_divider
    import complex_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned ITERS = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [2*DW+1:0] num_re,
    input  logic signed [2*DW+1:0] num_im,
    input  logic [2*DW:0]         den,
    output logic                  done,
    output logic [DW-1:0]         quo_re,
    output logic [DW-1:0]         quo_im
);
    localparam int unsigned NW   = 2 * DW + 2;
    localparam int unsigned DENW = 2 * DW + 1;
    localparam int unsigned QW   = ITERS;
    localparam int unsigned CW   = $clog2(ITERS);

    logic [QW-1:0]   qre_q, qim_q, qre_d, qim_d;
    logic [QW-1:0]   rre_q, rim_q, rre_d, rim_d;
    logic [DENW-1:0] den_q;
    logic            neg_re_q, neg_im_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;
    logic [NW-1:0]   mag_re, mag_im;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*QW-1:0] div_step(input logic [QW-1:0]   rem,
                                                 input logic [QW-1:0]   quo,
                                                 input logic [DENW-1:0] dv);
        logic [QW:0] trial;
        logic [QW:0] dext;
        trial = {rem, quo[QW-1]};
        dext = '0;
        dext[DENW-1:0] = dv;
        if (trial >= dext) begin
            return {QW'(trial - dext), quo[QW-2:0], 1'b1};
        end
        return {QW'(trial), quo[QW-2:0], 1'b0};
    endfunction

    assign mag_re = num_re[NW-1] ? -num_re : num_re;
    assign mag_im = num_im[NW-1] ? -num_im : num_im;

    // Next remainder/quotient for both lanes.
    always_comb begin
        {rre_d, qre_d} = div_step(rre_q, qre_q, den_q);
        {rim_d, qim_d} = div_step(rim_q, qim_q, den_q);
    end

    assign done   = run_q && (cnt_q == CW'(ITERS - 1));
    assign quo_re = DW'(neg_re_q ? -qre_d : qre_d);
    assign quo_im = DW'(neg_im_q ? -qim_d : qim_d);

    // Load on start, then iterate until the last step has been taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qre_q    <= '0;
            qim_q    <= '0;
            rre_q    <= '0;
            rim_q    <= '0;
            den_q    <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            qre_q    <= QW'(mag_re);
            qim_q    <= QW'(mag_im);
            rre_q    <= '0;
            rim_q    <= '0;
            den_q    <= den;
            neg_re_q <= num_re[NW-1];
            neg_im_q <= num_im[NW-1];
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            qre_q <= qre_d;
            qim_q <= qim_d;
            rre_q <= rre_d;
            rim_q <= rim_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/complex_exec_unit.sv
// complex_exec_unit: EX-stage unit for packed complex ops {re, im}.
// ADD/SUB/CONJ/CMP finish in one cycle; MUL uses one shared DWxDW multiplier over
// four cycles. COMPLEX_DIV_EN adds the DIV path (pre-products, prep, iterative divider);
// without it DIV behaves like an unsupported op.
module complex_exec_unit
    import complex_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned DIV_ITERS = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_op,
    input  logic [2*DW-1:0] op_a,
    input  logic [2*DW-1:0] op_b,
    input  logic [4:0]      dst,
    output logic [2*DW-1:0] result,
    output logic [4:0]      result_dst,
    output logic            result_valid,
    output logic            div_by_zero,
    output logic            busy,
    output logic            hazard_stall
);
    localparam int unsigned PW = 2 * DW;
`ifdef COMPLEX_DIV_EN
    localparam int unsigned NPROD = DMUL_CYCLES;
`else
    localparam int unsigned NPROD = MUL_CYCLES - 1;
`endif
    localparam logic [PW-1:0] CMP_TRUE = PW'(1) << DW;

    if (DIV_ITERS < 2 * DW + 1) begin : g_iters_chk
        $error("DIV_ITERS must be at least 2*DW+1");
    end

    cstate_e              state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic signed [DW-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic signed [PW-1:0] prod_q [NPROD];
    logic signed [PW-1:0] prod_d [NPROD];
    logic [PW-1:0]        result_q, result_d;
    logic [4:0]           dst_q, dst_d;
    logic                 valid_q, valid_d, dbz_q, dbz_d;
    logic signed [DW-1:0] mul_x, mul_y;
    logic signed [PW-1:0] mul_p;
    logic [DW-1:0]        in_a, in_b, in_c, in_d;

    assign in_a = op_a[PW-1:DW];
    assign in_b = op_a[DW-1:0];
    assign in_c = op_b[PW-1:DW];
    assign in_d = op_b[DW-1:0];

`ifdef COMPLEX_DIV_EN
    logic signed [PW+1:0] num_re, num_im;
    logic [PW:0]          den;
    logic                 div_start, div_done;
    logic [DW-1:0]        quo_re, quo_im;

    // Nr = ac + bd, Ni = bc - ad, D = cc + dd
    assign num_re = {{2{prod_q[0][PW-1]}}, prod_q[0]} + {{2{prod_q[1][PW-1]}}, prod_q[1]};
    assign num_im = {{2{prod_q[2][PW-1]}}, prod_q[2]} - {{2{prod_q[3][PW-1]}}, prod_q[3]};
    assign den    = {1'b0, prod_q[4]} + {1'b0, prod_q[5]};
    assign div_start = (state_q == StDprep);

    complex_divider #(
        .DW    (DW),
        .ITERS (DIV_ITERS)
    ) u_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (div_start),
        .num_re (num_re),
        .num_im (num_im),
        .den    (den),
        .done   (div_done),
        .quo_re (quo_re),
        .quo_im (quo_im)
    );
`endif

    // Shared multiplier operand select: MUL order ac, bd, ad, bc; DIV order ac, bd, bc, ad, cc, dd.
    always_comb begin
        mul_x = a_q;
        mul_y = c_q;
        if (state_q == StMul) begin
            case (cnt_q)
                3'd1:    begin mul_x = b_q; mul_y = d_q; end
                3'd2:    begin mul_x = a_q; mul_y = d_q; end
                3'd3:    begin mul_x = b_q; mul_y = c_q; end
                default: begin mul_x = a_q; mul_y = c_q; end
            endcase
`ifdef COMPLEX_DIV_EN
        end else if (state_q == StDmul) begin
            case (cnt_q)
                3'd1:    begin mul_x = b_q; mul_y = d_q; end
                3'd2:    begin mul_x = b_q; mul_y = c_q; end
                3'd3:    begin mul_x = a_q; mul_y = d_q; end
                3'd4:    begin mul_x = c_q; mul_y = c_q; end
                3'd5:    begin mul_x = d_q; mul_y = d_q; end
                default: begin mul_x = a_q; mul_y = c_q; end
            endcase
`endif
        end
    end

    assign mul_p = mul_x * mul_y;

    // FSM next state plus next values of the operand, product and result registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        prod_d   = prod_q;
        result_d = result_q;
        dst_d    = dst_q;
        valid_d  = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    c_d   = in_c;
                    d_d   = in_d;
                    dst_d = dst;
                    cnt_d = '0;
                    case (alu_op)
                        OP_ADD: begin
                            result_d = {in_a + in_c, in_b + in_d};
                            valid_d  = 1'b1;
                        end
                        OP_SUB: begin
                            result_d = {in_a - in_c, in_b - in_d};
                            valid_d  = 1'b1;
                        end
                        OP_CONJ: begin
                            result_d = {in_a, -in_b};
                            valid_d  = 1'b1;
                        end
                        OP_CMP: begin
                            result_d = (op_a == op_b) ? CMP_TRUE : '0;
                            valid_d  = 1'b1;
                        end
                        OP_MUL: state_d = StMul;
`ifdef COMPLEX_DIV_EN
                        OP_DIV: begin
                            if (op_b == '0) begin
                                result_d = '0;
                                dbz_d    = 1'b1;
                                valid_d  = 1'b1;
                            end else begin
                                state_d = StDmul;
                            end
                        end
`endif
                        default: begin
                            result_d = '0;
                            valid_d  = 1'b1;
                        end
                    endcase
                end
            end
            StMul: begin
                for (int i = 0; i < NPROD; i++) begin
                    if (cnt_q == 3'(i)) prod_d[i] = mul_p;
                end
                cnt_d = cnt_q + 3'd1;
                // Last product (bc) is used straight off the multiplier.
                if (cnt_q == 3'(MUL_CYCLES - 1)) begin
                    result_d = {DW'(prod_q[0] - prod_q[1]), DW'(prod_q[2] + mul_p)};
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end
            end
`ifdef COMPLEX_DIV_EN
            StDmul: begin
                for (int i = 0; i < NPROD; i++) begin
                    if (cnt_q == 3'(i)) prod_d[i] = mul_p;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(DMUL_CYCLES - 1)) state_d = StDprep;
            end
            StDprep: state_d = StDiter;
            StDiter: begin
                if (div_done) begin
                    result_d = {quo_re, quo_im};
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            for (int i = 0; i < NPROD; i++) prod_q[i] <= '0;
            result_q <= '0;
            dst_q    <= '0;
            valid_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            valid_q  <= valid_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result       = result_q;
    assign result_dst   = dst_q;
    assign result_valid = valid_q;
    assign div_by_zero  = dbz_q;
    assign busy         = (state_q != StIdle);
    assign hazard_stall = busy;

endmodule
